// File: rtl/cfg_loader_pkg.sv
// Shared definitions for the configuration frame loader.
// Holds the loader FSM state type and the default word geometry.
package cfg_loader_pkg;

    localparam int unsigned CFG_WORD_W_DEF    = 32;
    localparam int unsigned CFG_NUM_WORDS_DEF = 30;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2
    } state_e;

endpackage

// File: rtl/config_word_bank.sv
// NUM_WORDS x WORD_W register bank with a write enable per word.
// The bank is used twice: once for the shadow copy that collects a frame,
// and once for the active configuration that is committed from the shadow.
// Ports:
//   clk, reset : clock and synchronous active-high reset (clears all words)
//   we         : per-word write enable
//   wdata      : per-word write data, word k at [k*WORD_W +: WORD_W]
//   rdata      : current contents, same packing as wdata
module config_word_bank
    import cfg_loader_pkg::*;
#(
    parameter int unsigned WORD_W    = CFG_WORD_W_DEF,
    parameter int unsigned NUM_WORDS = CFG_NUM_WORDS_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_WORDS-1:0]        we,
    input  logic [WORD_W*NUM_WORDS-1:0] wdata,
    output logic [WORD_W*NUM_WORDS-1:0] rdata
);

    logic [WORD_W*NUM_WORDS-1:0] words_q;
    logic [WORD_W*NUM_WORDS-1:0] words_d;

    always_comb begin
        words_d = words_q;
        for (int unsigned k = 0; k < NUM_WORDS; k++) begin
            if (we[k]) begin
                words_d[k*WORD_W +: WORD_W] = wdata[k*WORD_W +: WORD_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            words_q <= '0;
        end else begin
            words_q <= words_d;
        end
    end

    assign rdata = words_q;

endmodule

// File: rtl/config_frame_loader.sv
// Loads a frame of configuration words into a shadow bank, verifies an XOR
// checksum word that follows the data, and on a match commits the frame's
// words into the active configuration in a single cycle.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   io_start          : frame request (IDLE only) with io_base / io_count
//   io_abort          : cancel a frame in progress (no commit, no done)
//   io_d_in/_valid    : data and checksum words; io_d_ready is the accept
//   io_busy           : frame in progress (LOAD or CHECK)
//   io_done           : one-cycle pulse when a frame finishes or is rejected
//   io_err            : outcome of the last finished frame
//   io_rb_addr/_data  : registered readback of one active word
//   io_configs_out    : all active words, word k at [k*WORD_W +: WORD_W]
module config_frame_loader
    import cfg_loader_pkg::*;
#(
    parameter  int unsigned WORD_W    = CFG_WORD_W_DEF,
    parameter  int unsigned NUM_WORDS = CFG_NUM_WORDS_DEF,
    localparam int unsigned AW        = $clog2(NUM_WORDS + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        io_start,
    input  logic [AW-1:0]               io_base,
    input  logic [AW-1:0]               io_count,
    input  logic                        io_abort,
    input  logic [WORD_W-1:0]           io_d_in,
    input  logic                        io_d_valid,
    output logic                        io_d_ready,
    output logic                        io_busy,
    output logic                        io_done,
    output logic                        io_err,
    input  logic [AW-1:0]               io_rb_addr,
    output logic [WORD_W-1:0]           io_rb_data,
    output logic [WORD_W*NUM_WORDS-1:0] io_configs_out
);

    state_e              state_q, state_d;
    logic [AW-1:0]       base_q, base_d;
    logic [AW-1:0]       count_q, count_d;
    logic [AW-1:0]       ptr_q, ptr_d;
    logic [WORD_W-1:0]   csum_q, csum_d;
    logic [WORD_W-1:0]   rb_data_q, rb_data_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                        busy;
    logic                        xfer;
    logic [AW:0]                 start_end;
    logic                        start_ok;
    logic [AW-1:0]               wr_idx;
    logic [NUM_WORDS-1:0]        commit_mask;
    logic [NUM_WORDS-1:0]        shadow_we;
    logic [NUM_WORDS-1:0]        active_we;
    logic [WORD_W*NUM_WORDS-1:0] shadow_wdata;
    logic [WORD_W*NUM_WORDS-1:0] shadow_words;
    logic [WORD_W*NUM_WORDS-1:0] active_words;

    assign busy       = (state_q == ST_LOAD) || (state_q == ST_CHECK);
    assign io_d_ready = busy && !io_abort;
    assign xfer       = io_d_valid && io_d_ready;

    // One extra bit so base+count cannot wrap past NUM_WORDS unnoticed.
    assign start_end = {1'b0, io_base} + {1'b0, io_count};
    assign start_ok  = (io_count != '0) && (start_end <= (AW+1)'(NUM_WORDS));

    // base+ptr stays below NUM_WORDS because the frame was range-checked.
    assign wr_idx = base_q + ptr_q;

    // Contiguous run of count_q ones starting at bit base_q.
    assign commit_mask = ({NUM_WORDS{1'b1}} >> (AW'(NUM_WORDS) - count_q)) << base_q;

    assign shadow_wdata = {NUM_WORDS{io_d_in}};
    assign shadow_we    = ((state_q == ST_LOAD) && xfer) ? (NUM_WORDS'(1) << wr_idx) : '0;
    assign active_we    = ((state_q == ST_CHECK) && xfer && (io_d_in == csum_q)) ? commit_mask : '0;

    config_word_bank #(
        .WORD_W    (WORD_W),
        .NUM_WORDS (NUM_WORDS)
    ) u_shadow_bank (
        .clk   (clk),
        .reset (reset),
        .we    (shadow_we),
        .wdata (shadow_wdata),
        .rdata (shadow_words)
    );

    config_word_bank #(
        .WORD_W    (WORD_W),
        .NUM_WORDS (NUM_WORDS)
    ) u_active_bank (
        .clk   (clk),
        .reset (reset),
        .we    (active_we),
        .wdata (shadow_words),
        .rdata (active_words)
    );

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        count_d = count_q;
        ptr_d   = ptr_q;
        csum_d  = csum_q;
        done_d  = 1'b0;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (io_start) begin
                    if (start_ok) begin
                        base_d  = io_base;
                        count_d = io_count;
                        ptr_d   = '0;
                        csum_d  = '0;
                        err_d   = 1'b0;
                        state_d = ST_LOAD;
                    end else begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (io_abort) begin
                    state_d = ST_IDLE;
                end else if (xfer) begin
                    csum_d = csum_q ^ io_d_in;
                    ptr_d  = ptr_q + AW'(1);
                    if (ptr_q == count_q - AW'(1)) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (io_abort) begin
                    state_d = ST_IDLE;
                end else if (xfer) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    err_d   = (io_d_in != csum_q);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Out-of-range readback addresses match no word and read as zero.
    always_comb begin
        rb_data_d = '0;
        for (int unsigned k = 0; k < NUM_WORDS; k++) begin
            if (AW'(k) == io_rb_addr) begin
                rb_data_d = active_words[k*WORD_W +: WORD_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            count_q   <= '0;
            ptr_q     <= '0;
            csum_q    <= '0;
            rb_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            count_q   <= count_d;
            ptr_q     <= ptr_d;
            csum_q    <= csum_d;
            rb_data_q <= rb_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign io_busy        = busy;
    assign io_done        = done_q;
    assign io_err         = err_q;
    assign io_rb_data     = rb_data_q;
    assign io_configs_out = active_words;

endmodule
